bios_loader: RTL
================

# bios_loader

Boot-time copier that sits directly downstream of the synchronous boot ROM. It walks every ROM address and packs byte pairs into 16-bit little-endian words. Each word is written into main memory through a request/acknowledge port. The CPU is held in reset until the whole image is in RAM. After that, the block stays idle until the next reset.

## Interface
- `AW`, default 14: ROM address width. The image is 2**AW bytes, which is 2**(AW-1) words. Minimum value is 2.
- `MAW`, default 19: memory word-address width.
- `BASE`, default 19'h7C000: memory word address that receives ROM word 0.
- `clock`, in, 1: single clock. Every register updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rom_ce`, out, 1: ROM clock enable. Asserted while a ROM read is in flight.
- `rom_address`, out, AW: ROM byte address.
- `rom_data`, in, 8: ROM registered read data. Valid one clock after the address is sampled.
- `mem_req`, out, 1: write request, held until acknowledged.
- `mem_addr`, out, MAW: word address of the write.
- `mem_wdata`, out, 16: write data. Bits [7:0] hold the even byte; bits [15:8] hold the odd byte.
- `mem_ack`, in, 1: memory accepted the write in this cycle.
- `busy`, out, 1: copy in progress.
- `done`, out, 1: copy complete. Sticky until reset.
- `cpu_hold`, out, 1: CPU reset request, equal to `~done`.

## Operation
- The state machine has six states: IDLE, LO_A, LO_D, HI_A, HI_D, WRITE, plus a terminal DONE state.
- **Reset values:**
  - state IDLE; word counter `wc` = 0.
  - `rom_ce` = 0, `rom_address` = 0.
  - `mem_req` = 0, `mem_addr` = BASE, `mem_wdata` = 0.
  - `busy` = 0, `done` = 0, so `cpu_hold` = 1.
- **IDLE → LO_A:** unconditional on the first clock after reset deasserts. Set `busy` = 1, `rom_ce` = 1, `rom_address` = {wc, 1'b0}.
- **LO_A → LO_D:** the ROM samples the address during this transition.
- **LO_D → HI_A:** capture `rom_data` into `mem_wdata[7:0]`, set `rom_address` = {wc, 1'b1}.
- **HI_A → HI_D:** the ROM samples the odd address.
- **HI_D → WRITE:** capture `rom_data` into `mem_wdata[15:8]`, set `rom_ce` = 0, set `mem_req` = 1, set `mem_addr` = BASE + wc. The addition is MAW bits wide and wraps modulo 2**MAW.
- **WRITE:**
  - `mem_req`, `mem_addr` and `mem_wdata` hold stable until `mem_ack` is sampled high.
  - On the ack edge, `mem_req` goes to 0.
  - If `wc` is all-ones (the last word), go to DONE: `busy` = 0, `done` = 1.
  - Otherwise increment `wc`, set `rom_ce` = 1, load the next even address, and go to LO_A.
- **DONE:** terminal. `rom_ce` = 0 and `mem_req` = 0. `mem_ack` is ignored. Only `reset` leaves this state.
- **Ignored ack:** `mem_ack` seen while `mem_req` = 0 has no effect in any state, and is not remembered.
- **Counter:** `wc` is AW-1 bits wide. The last-word compare is done on `wc` before the increment, so the counter never wraps within a run.
- **Reset mid-copy:** asynchronously returns every register to its reset value, including any outstanding `mem_req`. The copy restarts from word 0 after release, and no partial state is kept.

## Timing
- ROM read latency is one clock. Each byte takes 2 cycles: address cycle, then data cycle.
- One word costs 4 cycles of ROM reads plus the WRITE cycles. WRITE lasts at least one cycle when `mem_ack` is already high on the first WRITE cycle.
- With zero-wait memory (ack tied high), a word is written every 5 cycles.
- The first `mem_req` rises 5 clocks after reset release.
- `done` rises on the ack edge of the last word. `cpu_hold` falls combinationally with it.
- All outputs come from registers except `cpu_hold`, which is the inverter on `done`.

## Test plan
- **Zero-wait copy:** AW=4, ROM byte n = 8'h10+n, `mem_ack` tied high.
  - Exactly 8 writes, to BASE..BASE+7, with data 16'h1110, 16'h1312, …, 16'h1F1E.
  - `done` = 1 exactly 40 cycles after the first IDLE exit.
- **Wait states:** `mem_ack` delayed 3 cycles per request.
  - `mem_addr` and `mem_wdata` stay stable while `mem_req` is high.
  - One write per ack, no duplicates. Final memory image matches the zero-wait case.
- **Spurious ack:** pulse `mem_ack` during LO_A/HI_D and after `done`.
  - No extra writes, no state change, `done` stays 1.
- **Reset mid-copy:** assert `reset` in WRITE of word 3.
  - `mem_req` = 0 and `cpu_hold` = 1 immediately.
  - After release, writes restart at BASE with word 0 and complete all 8 words.
- **Address wrap:** MAW=4, BASE=4'hC, AW=4.
  - Write addresses are C, D, E, F, 0, 1, 2, 3.
- **Post-reset idle:** with reset held high for 10 cycles, `rom_ce` = 0, `mem_req` = 0, `busy` = 0, `done` = 0, `cpu_hold` = 1 throughout.

Source files
------------

// File: rtl/bios_loader.sv
// bios_loader: copies the synchronous boot ROM into main memory as 16-bit
// little-endian words, holding the CPU in reset until the image is in RAM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | first clock after reset, starts the even-byte read
// LO_A    | even byte address presented, ROM samples it
// LO_D    | even byte returned, captured into wdata[7:0]
// HI_A    | odd byte address presented, ROM samples it
// HI_D    | odd byte returned, captured into wdata[15:8]
// WRITE   | memory request held until acknowledged
// DONE    | image copied, terminal until reset
module bios_loader #(
    parameter int             AW   = 14,
    parameter int             MAW  = 19,
    parameter logic [MAW-1:0] BASE = 19'h7C000
) (
    input  logic           clock,
    input  logic           reset,
    output logic           rom_ce,
    output logic [AW-1:0]  rom_address,
    input  logic [7:0]     rom_data,
    output logic           mem_req,
    output logic [MAW-1:0] mem_addr,
    output logic [15:0]    mem_wdata,
    input  logic           mem_ack,
    output logic           busy,
    output logic           done,
    output logic           cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO_A,
        S_LO_D,
        S_HI_A,
        S_HI_D,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW-2:0] WC_ONE = 1;

    state_t         state_q;
    logic [AW-2:0]  wc_q;
    logic           rom_ce_q;
    logic [AW-1:0]  rom_address_q;
    logic           mem_req_q;
    logic [MAW-1:0] mem_addr_q;
    logic [15:0]    mem_wdata_q;
    logic           busy_q;
    logic           done_q;

    logic [AW-2:0]  wc_d;
    logic [MAW-1:0] mem_addr_d;
    logic           last_word;

    // Next word index, target word address and last-word detect.
    always_comb begin
        wc_d       = wc_q + WC_ONE;
        mem_addr_d = BASE + MAW'(wc_q);
        last_word  = &wc_q;
    end

    // Copy sequencer; every output except cpu_hold is registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wc_q          <= '0;
            rom_ce_q      <= 1'b0;
            rom_address_q <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= BASE;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q        <= 1'b1;
                    rom_ce_q      <= 1'b1;
                    rom_address_q <= {wc_q, 1'b0};
                    state_q       <= S_LO_A;
                end
                S_LO_A: begin
                    state_q <= S_LO_D;
                end
                S_LO_D: begin
                    mem_wdata_q[7:0] <= rom_data;
                    rom_address_q    <= {wc_q, 1'b1};
                    state_q          <= S_HI_A;
                end
                S_HI_A: begin
                    state_q <= S_HI_D;
                end
                S_HI_D: begin
                    mem_wdata_q[15:8] <= rom_data;
                    rom_ce_q          <= 1'b0;
                    mem_req_q         <= 1'b1;
                    mem_addr_q        <= mem_addr_d;
                    state_q           <= S_WRITE;
                end
                S_WRITE: begin
                    // Request, address and data stay frozen until the ack.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (last_word) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            wc_q          <= wc_d;
                            rom_ce_q      <= 1'b1;
                            rom_address_q <= {wc_d, 1'b0};
                            state_q       <= S_LO_A;
                        end
                    end
                end
                S_DONE: begin
                    rom_ce_q  <= 1'b0;
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_ce      = rom_ce_q;
    assign rom_address = rom_address_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cpu_hold    = ~done_q;

endmodule
